// File: rtl/em_lookup.sv
// Exact-match lookup engine: buffers 512-bit keys, scans a masked key table one entry
// per cycle and returns exactly one {hit, 2'b0, entry} index per key, in key order.
module em_lookup #(
    parameter int          DEPTH      = 16,
    parameter int          KEY_BUF    = 4,
    parameter logic [12:0] MISS_INDEX = 13'h1FFF
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_lookup_key_wr,
    input  logic [511:0] in_lookup_key,
    output logic         out_lookup_key_alf,
    output logic         out_lookup_index_wr,
    output logic [15:0]  out_lookup_index,
    input  logic         in_lookup_index_alf,
    input  logic         cfg2lookup_cs_n,
    output logic         lookup2cfg_ack_n,
    input  logic         cfg2lookup_rw,
    input  logic [31:0]  cfg2lookup_addr,
    input  logic [31:0]  cfg2lookup_wdata,
    output logic [31:0]  lookup2cfg_rdata
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int BW = $clog2(KEY_BUF);
    localparam int CW = BW + 1;
    localparam logic [AW-1:0] LAST_PTR = AW'(DEPTH - 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(KEY_BUF);
    localparam logic [CW-1:0] ALF_CNT  = CW'(KEY_BUF - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SEARCH = 2'd1,
        S_RESP   = 2'd2
    } search_state_t;

    typedef enum logic [1:0] {
        C_IDLE  = 2'd0,
        C_WRITE = 2'd1,
        C_READ  = 2'd2,
        C_ACK   = 2'd3
    } cfg_state_t;

    // Key buffer
    logic [511:0]  key_buf_mem [KEY_BUF];
    logic [BW-1:0] wr_ptr_reg;
    logic [BW-1:0] rd_ptr_reg;
    logic [CW-1:0] count_reg;
    logic [31:0]   key_in_cnt_reg;
    logic [31:0]   drop_cnt_reg;
    logic          buf_empty;
    logic          buf_full;
    logic          push;
    logic          pop;

    // Search engine
    search_state_t search_state_reg;
    logic [AW-1:0] ptr_reg;
    logic [511:0]  cur_key_reg;
    logic [15:0]   result_reg;
    logic [31:0]   hit_cnt_reg;
    logic [31:0]   miss_cnt_reg;
    logic          index_wr_reg;
    logic [15:0]   index_reg;
    logic          entry_hit;

    // Key table
    logic [511:0]     tkey_mem  [DEPTH];
    logic [511:0]     tmask_mem [DEPTH];
    logic [DEPTH-1:0] tvalid_reg;

    // Localbus
    cfg_state_t    cfg_state_reg;
    logic          cs_meta_reg;
    logic          cs_reg;
    logic          ack_n_reg;
    logic [31:0]   rdata_reg;
    logic [31:0]   stage_key_reg  [16];
    logic [31:0]   stage_mask_reg [16];
    logic [511:0]  stage_key_flat;
    logic [511:0]  stage_mask_flat;
    logic [7:0]    cfg_word;
    logic          write_done;
    logic          commit_en;
    logic [AW-1:0] commit_idx;
    logic [31:0]   read_word;
    logic          unused_bits;

    assign buf_empty          = (count_reg == '0);
    assign buf_full           = (count_reg == FULL_CNT);
    assign push               = in_lookup_key_wr && !buf_full;
    assign pop                = (search_state_reg == S_IDLE) && !buf_empty;
    assign out_lookup_key_alf = (count_reg >= ALF_CNT);

    always_ff @(posedge clk) begin
        if (push) begin
            key_buf_mem[wr_ptr_reg] <= in_lookup_key;
        end
    end

    // A push is judged against the count at the start of the cycle, so a
    // push arriving while full is dropped even if a pop happens alongside it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg     <= '0;
            rd_ptr_reg     <= '0;
            count_reg      <= '0;
            key_in_cnt_reg <= '0;
            drop_cnt_reg   <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg     <= wr_ptr_reg + 1'b1;
                key_in_cnt_reg <= key_in_cnt_reg + 32'd1;
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            if (in_lookup_key_wr && buf_full) begin
                drop_cnt_reg <= drop_cnt_reg + 32'd1;
            end
            case ({push, pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

    assign entry_hit = tvalid_reg[ptr_reg] &&
                       (((cur_key_reg ^ tkey_mem[ptr_reg]) & tmask_mem[ptr_reg]) == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            search_state_reg <= S_IDLE;
            ptr_reg          <= '0;
            cur_key_reg      <= '0;
            result_reg       <= '0;
            hit_cnt_reg      <= '0;
            miss_cnt_reg     <= '0;
            index_wr_reg     <= 1'b0;
            index_reg        <= '0;
        end else begin
            index_wr_reg <= 1'b0;
            case (search_state_reg)
                S_IDLE: begin
                    if (!buf_empty) begin
                        cur_key_reg      <= key_buf_mem[rd_ptr_reg];
                        ptr_reg          <= '0;
                        search_state_reg <= S_SEARCH;
                    end
                end
                S_SEARCH: begin
                    if (entry_hit) begin
                        result_reg       <= {1'b1, 2'b00, 13'(ptr_reg)};
                        search_state_reg <= S_RESP;
                    end else if (ptr_reg == LAST_PTR) begin
                        result_reg       <= {1'b0, 2'b00, MISS_INDEX};
                        search_state_reg <= S_RESP;
                    end else begin
                        ptr_reg <= ptr_reg + 1'b1;
                    end
                end
                S_RESP: begin
                    if (!in_lookup_index_alf) begin
                        index_wr_reg     <= 1'b1;
                        index_reg        <= result_reg;
                        search_state_reg <= S_IDLE;
                        if (result_reg[15]) begin
                            hit_cnt_reg <= hit_cnt_reg + 32'd1;
                        end else begin
                            miss_cnt_reg <= miss_cnt_reg + 32'd1;
                        end
                    end
                end
                default: search_state_reg <= S_IDLE;
            endcase
        end
    end

    assign out_lookup_index_wr = index_wr_reg;
    assign out_lookup_index    = index_reg;

    for (genvar gi = 0; gi < 16; gi++) begin : g_stage_flat
        assign stage_key_flat[32*gi +: 32]  = stage_key_reg[gi];
        assign stage_mask_flat[32*gi +: 32] = stage_mask_reg[gi];
    end

    assign cfg_word   = cfg2lookup_addr[9:2];
    assign commit_idx = cfg2lookup_wdata[AW-1:0];
    // Commits wait out an active search so a scan never sees a half-updated table.
    assign write_done = (cfg_state_reg == C_WRITE) &&
                        ((cfg_word != 8'h20) || (search_state_reg != S_SEARCH));
    assign commit_en  = write_done && (cfg_word == 8'h20);

    always_ff @(posedge clk) begin
        if (commit_en) begin
            tkey_mem[commit_idx]  <= stage_key_flat;
            tmask_mem[commit_idx] <= stage_mask_flat;
        end
    end

    always_comb begin
        read_word = '0;
        if (cfg_word < 8'h10) begin
            read_word = stage_key_reg[cfg_word[3:0]];
        end else if (cfg_word < 8'h20) begin
            read_word = stage_mask_reg[cfg_word[3:0]];
        end else begin
            case (cfg_word)
                8'h21:   read_word = {search_state_reg, 27'b0, out_lookup_key_alf,
                                      in_lookup_index_alf, buf_empty};
                8'h22:   read_word = key_in_cnt_reg;
                8'h23:   read_word = hit_cnt_reg;
                8'h24:   read_word = miss_cnt_reg;
                8'h25:   read_word = drop_cnt_reg;
                default: read_word = '0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cs_meta_reg   <= 1'b0;
            cs_reg        <= 1'b0;
            cfg_state_reg <= C_IDLE;
            ack_n_reg     <= 1'b1;
            rdata_reg     <= '0;
            tvalid_reg    <= '0;
            for (int i = 0; i < 16; i++) begin
                stage_key_reg[i]  <= '0;
                stage_mask_reg[i] <= '0;
            end
        end else begin
            cs_meta_reg <= !cfg2lookup_cs_n;
            cs_reg      <= cs_meta_reg;
            case (cfg_state_reg)
                C_IDLE: begin
                    if (cs_reg && ack_n_reg) begin
                        cfg_state_reg <= cfg2lookup_rw ? C_READ : C_WRITE;
                    end
                end
                C_WRITE: begin
                    if (write_done) begin
                        if (cfg_word < 8'h10) begin
                            stage_key_reg[cfg_word[3:0]] <= cfg2lookup_wdata;
                        end else if (cfg_word < 8'h20) begin
                            stage_mask_reg[cfg_word[3:0]] <= cfg2lookup_wdata;
                        end else if (commit_en) begin
                            tvalid_reg[commit_idx] <= cfg2lookup_wdata[31];
                        end
                        ack_n_reg     <= 1'b0;
                        cfg_state_reg <= C_ACK;
                    end
                end
                C_READ: begin
                    rdata_reg     <= read_word;
                    ack_n_reg     <= 1'b0;
                    cfg_state_reg <= C_ACK;
                end
                C_ACK: begin
                    if (!cs_reg) begin
                        ack_n_reg     <= 1'b1;
                        rdata_reg     <= '0;
                        cfg_state_reg <= C_IDLE;
                    end
                end
                default: cfg_state_reg <= C_IDLE;
            endcase
        end
    end

    assign lookup2cfg_ack_n = ack_n_reg;
    assign lookup2cfg_rdata = rdata_reg;

    assign unused_bits = ^{cfg2lookup_addr[31:10], cfg2lookup_addr[1:0], cfg2lookup_wdata};

endmodule

// File: tb/tb_em_lookup.sv
// Self-checking bench for em_lookup: directed vector table, multi-cycle corner
// sequences, and randomized bursts checked against a behavioural table model.
`timescale 1ns/1ps
module tb_em_lookup;
    localparam int          DEPTH    = 16;
    localparam int          KEY_BUF  = 4;
    localparam logic [12:0] MISS     = 13'h1FFF;
    localparam logic [15:0] MISS_IDX = {3'b000, MISS};

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         key_wr = 1'b0;
    logic [511:0] key = '0;
    logic         key_alf;
    logic         index_wr;
    logic [15:0]  index;
    logic         index_alf = 1'b0;
    logic         cs_n = 1'b1;
    logic         ack_n;
    logic         rw = 1'b0;
    logic [31:0]  addr = '0;
    logic [31:0]  wdata = '0;
    logic [31:0]  rdata;

    em_lookup #(.DEPTH(DEPTH), .KEY_BUF(KEY_BUF), .MISS_INDEX(MISS)) dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .in_lookup_key_wr    (key_wr),
        .in_lookup_key       (key),
        .out_lookup_key_alf  (key_alf),
        .out_lookup_index_wr (index_wr),
        .out_lookup_index    (index),
        .in_lookup_index_alf (index_alf),
        .cfg2lookup_cs_n     (cs_n),
        .lookup2cfg_ack_n    (ack_n),
        .cfg2lookup_rw       (rw),
        .cfg2lookup_addr     (addr),
        .cfg2lookup_wdata    (wdata),
        .lookup2cfg_rdata    (rdata)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    logic [15:0] idx_q[$];
    int          cyc_q[$];
    always @(negedge clk) begin
        if (index_wr === 1'b1) begin
            idx_q.push_back(index);
            cyc_q.push_back(cyc);
        end
    end

    int checks = 0;
    int passed = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    // Behavioural table model: first valid entry whose masked key matches wins.
    logic [511:0] m_key  [DEPTH];
    logic [511:0] m_mask [DEPTH];
    logic         m_valid[DEPTH];
    logic [511:0] stage_k;
    logic [511:0] stage_m;

    function automatic logic [15:0] model_lookup(input logic [511:0] k);
        for (int e = 0; e < DEPTH; e++) begin
            if (m_valid[e] && (((k ^ m_key[e]) & m_mask[e]) == '0)) return {3'b100, 13'(e)};
        end
        return MISS_IDX;
    endfunction

    function automatic int model_latency(input logic [15:0] idx);
        return idx[15] ? 4 + int'(idx[12:0]) : DEPTH + 3;
    endfunction

    function automatic logic [511:0] rand512();
        logic [511:0] r;
        for (int w = 0; w < 16; w++) r[32*w +: 32] = $urandom;
        return r;
    endfunction

    task automatic bus_xfer(input logic is_read, input logic [7:0] word, input logic [31:0] data,
                            output logic [31:0] rd);
        int n;
        rd = '0;
        @(posedge clk); #1;
        rw = is_read; addr = {22'b0, word, 2'b00}; wdata = data; cs_n = 1'b0;
        n = 0;
        while (ack_n !== 1'b0 && n < 100) begin @(posedge clk); #1; n++; end
        if (ack_n !== 1'b0) begin
            checks++;
            $display("FAIL bus_ack word %h: ack_n %b, expected 0", word, ack_n);
        end
        rd = rdata;
        cs_n = 1'b1;
        n = 0;
        while (ack_n !== 1'b1 && n < 100) begin @(posedge clk); #1; n++; end
        if (ack_n !== 1'b1) begin
            checks++;
            $display("FAIL bus_release word %h: ack_n %b, expected 1", word, ack_n);
        end
    endtask

    task automatic bus_write(input logic [7:0] word, input logic [31:0] data);
        logic [31:0] dummy;
        bus_xfer(1'b0, word, data, dummy);
    endtask

    task automatic bus_read(input logic [7:0] word, output logic [31:0] rd);
        bus_xfer(1'b1, word, 32'h0, rd);
    endtask

    task automatic stage(input logic [511:0] k, input logic [511:0] m);
        for (int w = 0; w < 16; w++) bus_write(8'(w), k[32*w +: 32]);
        for (int w = 0; w < 16; w++) bus_write(8'(16 + w), m[32*w +: 32]);
        stage_k = k;
        stage_m = m;
    endtask

    task automatic commit(input int e, input logic v);
        bus_write(8'h20, {v, 18'b0, 13'(e)});
        m_key[e % DEPTH]   = stage_k;
        m_mask[e % DEPTH]  = stage_m;
        m_valid[e % DEPTH] = v;
    endtask

    task automatic program_entry(input int e, input logic [511:0] k, input logic [511:0] m);
        stage(k, m);
        commit(e, 1'b1);
    endtask

    task automatic send_key(input logic [511:0] k, output int c0);
        @(posedge clk); #1;
        key_wr = 1'b1; key = k; c0 = cyc;
        @(posedge clk); #1;
        key_wr = 1'b0;
    endtask

    task automatic get_index(input string name, input int budget, output logic [15:0] idx,
                             output int at);
        int n = 0;
        while (idx_q.size() == 0 && n < budget) begin @(posedge clk); #1; n++; end
        if (idx_q.size() == 0) begin
            checks++;
            $display("FAIL %s: no index_wr within %0d cycles, expected one", name, budget);
            idx = 16'h0;
            at  = -1;
        end else begin
            idx = idx_q.pop_front();
            at  = cyc_q.pop_front();
        end
    endtask

    typedef struct {
        logic [511:0] key;
        logic [15:0]  exp_idx;
        int           exp_lat;
    } vec_t;

    vec_t         vecs[4];
    logic [511:0] bkeys[6];
    logic [511:0] rkeys[$];
    logic [15:0]  rexp[$];
    logic [511:0] rk;
    logic [31:0]  rd;
    logic [15:0]  got;
    int           at;
    int           c0;
    int           n_burst;
    int           j;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        for (int e = 0; e < DEPTH; e++) begin
            m_key[e] = '0; m_mask[e] = '0; m_valid[e] = 1'b0;
        end
        stage_k = '0;
        stage_m = '0;

        vecs[0] = '{512'h1234,      16'h8003, 7};
        vecs[1] = '{512'hFFAB,      16'h8000, 4};
        vecs[2] = '{512'h00AC,      MISS_IDX, DEPTH + 3};
        vecs[3] = '{512'h5555_0000, 16'h8002, 6};

        repeat (3) @(posedge clk);
        #1;
        check("rst index_wr", 32'(index_wr), 32'h0);
        check("rst index",    32'(index),    32'h0);
        check("rst key_alf",  32'(key_alf),  32'h0);
        check("rst ack_n",    32'(ack_n),    32'h1);
        check("rst rdata",    rdata,         32'h0);
        rst_n = 1'b1;
        bus_read(8'h21, rd);
        check("status idle", rd, 32'h0000_0001);

        program_entry(3, 512'h1234, '1);
        program_entry(0, 512'hAB, 512'hFF);
        program_entry(2, 512'h5555_0000, 512'hFFFF_0000);
        program_entry(5, 512'h5555_0000, 512'hFFFF_0000);

        for (int i = 0; i < 4; i++) begin
            send_key(vecs[i].key, c0);
            get_index($sformatf("vec%0d", i), 60, got, at);
            check($sformatf("vec%0d index", i), 32'(got), 32'(vecs[i].exp_idx));
            check($sformatf("vec%0d latency", i), 32'(at - c0), 32'(vecs[i].exp_lat));
            $display("vec%0d key=%h index=%h latency=%0d", i, vecs[i].key[31:0], got, at - c0);
        end

        bus_read(8'h22, rd); check("key_in_cnt", rd, 32'd4);
        bus_read(8'h23, rd); check("hit_cnt", rd, 32'd3);
        bus_read(8'h24, rd); check("miss_cnt", rd, 32'd1);
        bus_read(8'h00, rd); check("stage key word0", rd, 32'h5555_0000);
        bus_read(8'h10, rd); check("stage mask word0", rd, 32'hFFFF_0000);
        bus_read(8'h30, rd); check("unmapped word", rd, 32'h0);

        // Invalidate entry 2: the next match in priority order is entry 5.
        commit(2, 1'b0);
        send_key(512'h5555_0000, c0);
        get_index("prio", 60, got, at);
        check("prio index", 32'(got), 32'h8005);
        check("prio latency", 32'(at - c0), 32'd9);
        $display("prio key=55550000 index=%h latency=%0d", got, at - c0);

        // Backpressure holds the response in RESP.
        index_alf = 1'b1;
        send_key(512'h1234, c0);
        repeat (25) @(posedge clk);
        #1;
        check("bp held", 32'(idx_q.size()), 32'h0);
        bus_read(8'h21, rd);
        check("status resp", rd, 32'h8000_0003);
        index_alf = 1'b0;
        get_index("bp release", 20, got, at);
        check("bp index", 32'(got), 32'h8003);
        repeat (10) @(posedge clk);
        #1;
        check("bp single", 32'(idx_q.size()), 32'h0);
        $display("backpressure index=%h", got);

        // Buffer full: KEY_BUF+2 back-to-back keys with the index FIFO almost full.
        bkeys[0] = 512'h1234; bkeys[1] = 512'hFFAB; bkeys[2] = 512'h00AC;
        bkeys[3] = 512'h5555_0000; bkeys[4] = 512'h1234; bkeys[5] = 512'hFFAB;
        index_alf = 1'b1;
        for (int i = 0; i < KEY_BUF + 2; i++) begin
            @(posedge clk); #1;
            check($sformatf("alf before key%0d", i), 32'(key_alf), (i >= KEY_BUF) ? 32'h1 : 32'h0);
            key_wr = 1'b1; key = bkeys[i];
        end
        @(posedge clk); #1;
        key_wr = 1'b0;
        check("alf after burst", 32'(key_alf), 32'h1);
        bus_read(8'h25, rd);
        check("drop_cnt", rd, 32'd1);
        index_alf = 1'b0;
        for (int i = 0; i < KEY_BUF + 1; i++) begin
            get_index($sformatf("burst%0d", i), 100, got, at);
            check($sformatf("burst%0d index", i), 32'(got), 32'(model_lookup(bkeys[i])));
            $display("burst%0d index=%h", i, got);
        end
        repeat (40) @(posedge clk);
        #1;
        check("burst dropped key silent", 32'(idx_q.size()), 32'h0);

        // Randomized bursts against the model.
        for (int e = 8; e < 12; e++) program_entry(e, rand512(), rand512());
        for (int r = 0; r < 10; r++) begin
            n_burst = $urandom_range(1, 3);
            rkeys.delete();
            rexp.delete();
            for (int i = 0; i < n_burst; i++) begin
                j = $urandom_range(0, DEPTH - 1);
                if ($urandom_range(0, 3) != 0) rk = m_key[j] ^ (rand512() & ~m_mask[j]);
                else rk = rand512();
                rkeys.push_back(rk);
                rexp.push_back(model_lookup(rk));
            end
            for (int i = 0; i < n_burst; i++) begin
                @(posedge clk); #1;
                key_wr = 1'b1; key = rkeys[i];
                if (i == 0) c0 = cyc;
            end
            @(posedge clk); #1;
            key_wr = 1'b0;
            for (int i = 0; i < n_burst; i++) begin
                get_index($sformatf("rnd%0d.%0d", r, i), 100, got, at);
                check($sformatf("rnd%0d.%0d index", r, i), 32'(got), 32'(rexp[i]));
                if (i == 0) check($sformatf("rnd%0d latency", r), 32'(at - c0),
                                  32'(model_latency(rexp[0])));
                $display("rnd%0d.%0d index=%h expected=%h", r, i, got, rexp[i]);
            end
        end

        // Reset in the middle of a search.
        send_key(512'h00AC, c0);
        repeat (4) @(posedge clk);
        #3;
        rst_n = 1'b0;
        for (int e = 0; e < DEPTH; e++) m_valid[e] = 1'b0;
        #1;
        check("midrst index_wr", 32'(index_wr), 32'h0);
        check("midrst index",    32'(index),    32'h0);
        check("midrst key_alf",  32'(key_alf),  32'h0);
        check("midrst ack_n",    32'(ack_n),    32'h1);
        check("midrst rdata",    rdata,         32'h0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (DEPTH + 10) @(posedge clk);
        #1;
        check("midrst no index", 32'(idx_q.size()), 32'h0);
        bus_read(8'h23, rd); check("midrst hit_cnt", rd, 32'h0);
        bus_read(8'h22, rd); check("midrst key_in_cnt", rd, 32'h0);
        send_key(512'h1234, c0);
        get_index("post rst", 60, got, at);
        check("post rst index", 32'(got), 32'(model_lookup(512'h1234)));
        check("post rst latency", 32'(at - c0), 32'(DEPTH + 3));
        $display("post reset index=%h latency=%0d", got, at - c0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
